// File: rtl/riscv_pkg.sv
// Shared definitions for the core's memory stage: FSM states, funct3 access codes
// and the helper that maps funct3 to an access width.
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } dmem_state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } acc_size_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Stores only know SB/SH; the unsigned codes fall back to word like any other code.
   function automatic acc_size_e f3_size(input logic [2:0] f3, input logic is_load);
      acc_size_e sz;
      sz = SZ_W;
      if (f3 == F3_B || (is_load && f3 == F3_BU))
         sz = SZ_B;
      else if (f3 == F3_H || (is_load && f3 == F3_HU))
         sz = SZ_H;
      return sz;
   endfunction

endpackage

// File: rtl/dmem_lane_ext.sv
// Load lane select and sign/zero extension: picks the byte or half addressed by
// i_addr_lo out of a RAM word and extends it according to funct3.
module dmem_lane_ext
   import riscv_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
   assign w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];

   // NOTE: o_data gets a default before the case, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      o_data = i_word;
      case (i_funct3)
         F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
         F3_H:    o_data = {{16{w_half[15]}}, w_half};
         F3_BU:   o_data = {24'd0, w_byte};
         F3_HU:   o_data = {16'd0, w_half};
         F3_W:    o_data = i_word;
         default: o_data = i_word;
      endcase
   end

endmodule

// File: rtl/dmem_unit.sv
// Data-memory stage: byte/half/word loads and stores to a word RAM, stalling the core
// for LATENCY cycles per access. Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module dmem_unit
   import riscv_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset_,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] writeData,
   output logic [31:0] readDataDMem,
   output logic        stall,
   output logic        misalign
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
   localparam bit         DIRECT   = (LATENCY == 1);

   dmem_state_e   r_state;
   logic [3:0]    r_cnt;
   logic [AW+1:0] r_addr;
   logic [31:0]   r_wdata;
   logic [2:0]    r_funct3;
   logic          r_is_read;
   logic [31:0]   r_rdata;
   logic          r_misalign;
   logic [31:0]   r_mem [DEPTH];

   logic          w_req;
   logic          w_in_idle;
   logic          w_op_fire;
   logic          w_op_is_read;
   logic [AW+1:0] w_op_addr;
   logic [31:0]   w_op_wdata;
   logic [2:0]    w_op_funct3;
   acc_size_e     w_size;
   logic [1:0]    w_lo;
   logic [AW-1:0] w_idx;
   logic          w_mis;
   logic          w_we;
   logic [3:0]    w_be;
   logic [31:0]   w_lane_data;
   logic [31:0]   w_rd_word;
   logic [31:0]   w_load_data;
   logic          w_unused_addr;

   assign w_req     = memread | memwrite;
   assign w_in_idle = (r_state == IDLE);

   // Live inputs feed the operation only when it fires straight out of IDLE (LATENCY==1).
   assign w_op_addr    = w_in_idle ? addr[AW+1:0] : r_addr;
   assign w_op_wdata   = w_in_idle ? writeData    : r_wdata;
   assign w_op_funct3  = w_in_idle ? funct3       : r_funct3;
   assign w_op_is_read = w_in_idle ? memread      : r_is_read;

   // The request cycle is the first stalled cycle, so WAIT ends on the edge where cnt leaves 1.
   assign w_op_fire = !reset_ &&
                      ((w_in_idle && w_req && DIRECT) || (r_state == WAIT && r_cnt == 4'd1));

   assign w_size = f3_size(w_op_funct3, w_op_is_read);
   assign w_idx  = w_op_addr[AW+1:2];

   always_comb begin
      w_lo = w_op_addr[1:0];
      if (w_size == SZ_H)
         w_lo[0] = 1'b0;
      else if (w_size == SZ_W)
         w_lo = 2'b00;
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   assign w_mis = (w_size == SZ_H && w_op_addr[0]) ||
                  (w_size == SZ_W && w_op_addr[1:0] != 2'b00);
`else
   assign w_mis = 1'b0;
`endif

   always_comb begin
      w_be        = 4'b1111;
      w_lane_data = w_op_wdata;
      case (w_size)
         SZ_B: begin
            w_be        = 4'b0001 << w_lo;
            w_lane_data = {4{w_op_wdata[7:0]}};
         end
         SZ_H: begin
            w_be        = w_lo[1] ? 4'b1100 : 4'b0011;
            w_lane_data = {2{w_op_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign w_we = w_op_fire && !w_op_is_read && !w_mis;

   // NOTE: the RAM array is deliberately left out of reset so it maps onto a memory macro, not flops.
   always_ff @(posedge clock) begin
      if (w_we) begin
         for (int i = 0; i < 4; i++)
            if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_lane_data[8*i +: 8];
      end
   end

   assign w_rd_word = r_mem[w_idx];

   dmem_lane_ext u_lane_ext (
      .i_word    (w_rd_word),
      .i_addr_lo (w_lo),
      .i_funct3  (w_op_funct3),
      .o_data    (w_load_data)
   );

   // NOTE: non-blocking assignments here so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset_) begin
      if (reset_) begin
         r_state    <= IDLE;
         r_cnt      <= 4'd0;
         r_addr     <= '0;
         r_wdata    <= 32'd0;
         r_funct3   <= 3'd0;
         r_is_read  <= 1'b0;
         r_rdata    <= 32'd0;
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= 1'b0;
         if (w_op_fire) begin
            r_misalign <= w_mis;
            if (w_op_is_read) r_rdata <= w_mis ? 32'd0 : w_load_data;
         end
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_addr    <= addr[AW+1:0];
                  r_wdata   <= writeData;
                  r_funct3  <= funct3;
                  r_is_read <= memread;
                  if (DIRECT) begin
                     r_state <= DONE;
                     r_cnt   <= 4'd0;
                  end else begin
                     r_state <= WAIT;
                     r_cnt   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) r_state <= DONE;
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign stall         = !reset_ && ((w_in_idle && w_req) || r_state == WAIT);
   assign readDataDMem  = r_rdata;
   assign misalign      = r_misalign;
   assign w_unused_addr = ^addr[31:AW+2];

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: directed vector table, reset/misalign sequences,
// then random accesses checked against a byte-array reference model.
module tb_dmem_unit;

   localparam int DEPTH   = 256;
   localparam int LATENCY = 2;
   localparam int MEMB    = DEPTH * 4;

   logic        clock;
   logic        reset_;
   logic        memread;
   logic        memwrite;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] writeData;
   logic [31:0] readDataDMem;
   logic        stall;
   logic        misalign;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  m_mem [MEMB];
   logic [31:0] last_load = 32'd0;

   dmem_unit #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clock        (clock),
      .reset_       (reset_),
      .memread      (memread),
      .memwrite     (memwrite),
      .funct3       (funct3),
      .addr         (addr),
      .writeData    (writeData),
      .readDataDMem (readDataDMem),
      .stall        (stall),
      .misalign     (misalign)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference model: memory is a flat byte array, little-endian, wrapping at MEMB.
   function automatic int acc_bytes(input logic [2:0] f3, input logic is_load);
      if (f3 == 3'b000 || (is_load && f3 == 3'b100)) return 1;
      if (f3 == 3'b001 || (is_load && f3 == 3'b101)) return 2;
      return 4;
   endfunction

   function automatic logic model_mis(input int n, input logic [31:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
      return (int'(a[1:0]) % n) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int base_of(input int n, input logic [31:0] a);
      int off;
      off = int'(a % 32'(MEMB));
      return off - (off % n);
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input int n, input logic [31:0] a);
      logic [31:0] v;
      int b;
      v = 32'd0;
      b = base_of(n, a);
      for (int i = 0; i < n; i++) v[8*i +: 8] = m_mem[b + i];
      if ((f3 == 3'b000 || f3 == 3'b001) && v[8*n-1])
         for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   task automatic model_store(input int n, input logic [31:0] a, input logic [31:0] wd);
      int b;
      b = base_of(n, a);
      for (int i = 0; i < n; i++) m_mem[b + i] = wd[8*i +: 8];
   endtask

   // One memory instruction, entered and left one time unit after a rising edge.
   task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input bit keep,
                         input string tag, output logic [31:0] got);
      int n;
      int stalls;
      logic mis;
      logic [31:0] exp;
      n   = acc_bytes(f3, rd);
      mis = model_mis(n, a);
      if (rd) begin
         exp       = mis ? 32'd0 : model_load(f3, n, a);
         last_load = exp;
      end else begin
         exp = last_load;
         if (!mis) model_store(n, a, wd);
      end
      memread   = rd;
      memwrite  = wr;
      funct3    = f3;
      addr      = a;
      writeData = wd;
      stalls    = 0;
      @(negedge clock);
      while (stall && stalls < 64) begin
         stalls++;
         @(negedge clock);
      end
      got = readDataDMem;
      check({tag, "_data"}, got, exp);
      check({tag, "_stall"}, 32'(stalls), 32'(LATENCY));
      check({tag, "_mis"}, {31'd0, misalign}, {31'd0, mis});
      if (!keep) begin
         memread  = 1'b0;
         memwrite = 1'b0;
      end
      @(posedge clock);
      #1;
   endtask

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [21];

   initial begin
      logic [31:0] got;
      logic [31:0] a;
      logic        rd;
      logic        wr;
      int          kind;

      vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
      vecs[1]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
      vecs[2]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'h0000_0080, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0013, 32'h0,         32'hFFFF_FF80};
      vecs[4]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0013, 32'h0,         32'h0000_0080};
      vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h80AD_BEEF};
      vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h0000_1234, 32'h80AD_BEEF};
      vecs[7]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0012, 32'h0,         32'h0000_1234};
      vecs[8]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0011, 32'h0,         32'h0000_00BE};
      vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h1234_BEEF};
      vecs[10] = '{1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'hA5A5_A5A5, 32'h1234_BEEF};
      vecs[11] = '{1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5};
      vecs[12] = '{1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'hFFFF_FFFF, 32'h1234_BEEF};
      vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h1234_BEEF};
      vecs[14] = '{1'b1, 1'b0, 3'b011, 32'h0000_0400, 32'h0,         32'hA5A5_A5A5};
      vecs[15] = '{1'b0, 1'b1, 3'b111, 32'h0000_0024, 32'h0BAD_F00D, 32'hA5A5_A5A5};
      vecs[16] = '{1'b1, 1'b0, 3'b010, 32'h0000_0024, 32'h0,         32'h0BAD_F00D};
      vecs[17] = '{1'b1, 1'b0, 3'b000, 32'h0000_0010, 32'h0,         32'hFFFF_FFEF};
      vecs[18] = '{1'b1, 1'b0, 3'b001, 32'h0000_0010, 32'h0,         32'hFFFF_BEEF};
      vecs[19] = '{1'b1, 1'b0, 3'b101, 32'h0000_0012, 32'h0,         32'h0000_1234};
      vecs[20] = '{1'b1, 1'b0, 3'b000, 32'h0000_0012, 32'h0,         32'h0000_0034};

      // Reset with a request held: stall must stay low while reset is asserted.
      reset_    = 1'b1;
      memread   = 1'b1;
      memwrite  = 1'b0;
      funct3    = 3'b010;
      addr      = 32'd0;
      writeData = 32'd0;
      repeat (2) @(posedge clock);
      #1;
      check("reset_stall", {31'd0, stall}, 32'd0);
      check("reset_rdata", readDataDMem, 32'd0);
      check("reset_mis", {31'd0, misalign}, 32'd0);
      memread = 1'b0;
      @(negedge clock);
      reset_ = 1'b0;
      @(posedge clock);
      #1;

      // Fill the whole RAM so every later load has a defined model value.
      for (int w = 0; w < DEPTH; w++)
         run_op(1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom, 1'b0, $sformatf("init%0d", w), got);

      for (int i = 0; i < 21; i++) begin
         run_op(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].wd, 1'b0,
                $sformatf("vec%0d", i), got);
         check($sformatf("vec%0d_const", i), got, vecs[i].exp);
      end

      // Reset during WAIT of a store aborts it without touching the RAM.
      run_op(1'b0, 1'b1, 3'b010, 32'h20, 32'h1111_2222, 1'b0, "pre_sw", got);
      memwrite  = 1'b1;
      funct3    = 3'b010;
      addr      = 32'h20;
      writeData = 32'h55;
      @(negedge clock);
      check("abort_req_stall", {31'd0, stall}, 32'd1);
      @(posedge clock);
      #1;
      check("abort_wait_stall", {31'd0, stall}, 32'd1);
      reset_ = 1'b1;
      #1;
      check("abort_rst_stall", {31'd0, stall}, 32'd0);
      check("abort_rst_rdata", readDataDMem, 32'd0);
      @(negedge clock);
      @(negedge clock);
      check("abort_rst_stall2", {31'd0, stall}, 32'd0);
      check("abort_rst_mis", {31'd0, misalign}, 32'd0);
      memwrite  = 1'b0;
      reset_    = 1'b0;
      last_load = 32'd0;
      @(posedge clock);
      #1;
      run_op(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, "abort_lw", got);
      check("abort_lw_const", got, 32'h1111_2222);

      run_op(1'b1, 1'b0, 3'b000, 32'h10, 32'h0, 1'b0, "pre_mis_lb", got);
`ifdef DMEM_MISALIGN_TRAP_EN
      run_op(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, 1'b0, "mis_lw", got);
      check("mis_lw_const", got, 32'h0);
      check("mis_pulse_end", {31'd0, misalign}, 32'd0);
      run_op(1'b0, 1'b1, 3'b010, 32'h22, 32'hFFFF_FFFF, 1'b0, "mis_sw", got);
      run_op(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, "mis_chk", got);
      check("mis_chk_const", got, 32'h1111_2222);
`else
      run_op(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, 1'b0, "unal_lw", got);
      check("unal_lw_const", got, 32'h1111_2222);
      check("unal_mis_low", {31'd0, misalign}, 32'd0);
`endif

      // Random traffic; some requests are held through DONE like a stalled core would.
      for (int k = 0; k < 300; k++) begin
         kind = $urandom_range(0, 2);
         rd   = (kind != 1);
         wr   = (kind != 0);
         a    = $urandom;
         if (k % 2 == 0) a[9:6] = 4'd0;
         run_op(rd, wr, 3'($urandom_range(0, 7)), a, $urandom,
                1'($urandom_range(0, 1)), $sformatf("rnd%0d", k), got);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
